// File: rtl/adc_seq_pkg.sv
// Shared types and sizing for the ADC conversion sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    OUT    = 3'd4
  } state_t;

  localparam int DEF_RESOLUTION   = 8;
  localparam int DEF_MAX_AVG_LOG2 = 4;
  // Holds the sum of 2^MAX_AVG_LOG2 full-scale samples without overflow.
  localparam int ACC_W = DEF_RESOLUTION + DEF_MAX_AVG_LOG2;

  function automatic int acc_width(input int resolution, input int max_avg_log2);
    return resolution + max_avg_log2;
  endfunction

endpackage

// File: rtl/adc_seq_next_ch.sv
// Masked priority pick: lowest set bit of mask_i strictly above idx_i.
// Driving idx_i with -1 yields the lowest set bit of the whole mask.
module adc_seq_next_ch
  import adc_seq_pkg::*;
#(
  parameter int  NUM_CH = 4,
  localparam int CW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic signed [CW:0] idx_i,
  output logic [CW-1:0]     next_o,
  output logic              found_o
);

  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found_o && mask_i[k] && (k > int'(idx_i))) begin
        next_o  = CW'(k);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Steps the analog mux through the enabled channels, averages 2^avg ADC
// conversions per channel and hands out one tagged result per channel.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int  RESOLUTION     = 8,
  parameter int  NUM_CH         = 4,
  parameter int  MAX_AVG_LOG2   = 4,
  parameter int  SETTLE_CYCLES  = 4,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int CW             = $clog2(NUM_CH),
  localparam int AW             = $clog2(MAX_AVG_LOG2 + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  continuous_i,
  input  logic [NUM_CH-1:0]     chan_mask_i,
  input  logic [AW-1:0]         avg_log2_i,
  output logic [CW-1:0]         mux_sel_o,
  output logic                  adc_start_o,
  input  logic                  adc_sample_i,
  input  logic                  adc_rdy_i,
  input  logic [RESOLUTION-1:0] adc_result_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [RESOLUTION-1:0] res_data_o,
  output logic [CW-1:0]         res_chan_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output state_t                state_o
);

  localparam int ACC_BITS = acc_width(RESOLUTION, MAX_AVG_LOG2);
  localparam int CNT_W    = MAX_AVG_LOG2 + 1;
  localparam int SW       = $clog2(SETTLE_CYCLES + 2);
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [AW-1:0]       avg_q, avg_d, avg_sat;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                stop_q, stop_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                start_q, rdy_q, rdy_rise;
  logic [CW-1:0]       next_ch, first_ch;
  logic                next_found, first_found;
  logic                sample_unused;

  // The sampling phase is not needed for scheduling.
  assign sample_unused = adc_sample_i;
  assign rdy_rise      = adc_rdy_i & ~rdy_q;
  assign avg_sat       = (avg_log2_i > AW'(MAX_AVG_LOG2)) ? AW'(MAX_AVG_LOG2) : avg_log2_i;

  adc_seq_next_ch #(.NUM_CH(NUM_CH)) u_next (
    .mask_i (mask_q),
    .idx_i  ({1'b0, chan_q}),
    .next_o (next_ch),
    .found_o(next_found)
  );

  adc_seq_next_ch #(.NUM_CH(NUM_CH)) u_first (
    .mask_i (chan_mask_i),
    .idx_i  ({(CW + 1){1'b1}}),
    .next_o (first_ch),
    .found_o(first_found)
  );

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    mask_d   = mask_q;
    avg_d    = avg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    tmo_d    = tmo_q;
    stop_d   = stop_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && first_found) begin
          mask_d   = chan_mask_i;
          avg_d    = avg_sat;
          chan_d   = first_ch;
          err_d    = 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (!enable_i) state_d = IDLE;
        else if (settle_q == SW'(SETTLE_CYCLES)) state_d = START;
        else settle_d = settle_q + SW'(1);
      end
      START: begin
        tmo_d  = '0;
        stop_d = 1'b0;
        state_d = enable_i ? WAIT : IDLE;
      end
      WAIT: begin
        if (!enable_i) stop_d = 1'b1;
        if (rdy_rise) begin
          // A stop lets the conversion finish but throws its sample away.
          if (stop_q || !enable_i) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d   = acc_q + ACC_BITS'(adc_result_i);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == (CNT_W'(1) << avg_q)) ? OUT : START;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      OUT: begin
        if (res_ready_i) begin
          acc_d    = '0;
          cnt_d    = '0;
          settle_d = '0;
          if (!enable_i) begin
            state_d = IDLE;
          end else if (next_found) begin
            chan_d  = next_ch;
            state_d = SETTLE;
          end else if (continuous_i) begin
            mask_d  = chan_mask_i;
            avg_d   = avg_sat;
            chan_d  = first_ch;
            state_d = first_found ? SETTLE : IDLE;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      chan_q   <= '0;
      mask_q   <= '0;
      avg_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      tmo_q    <= '0;
      stop_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      mask_q   <= mask_d;
      avg_q    <= avg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      stop_q   <= stop_d;
      err_q    <= err_d;
      done_q   <= done_d;
      start_q  <= (state_d == START);
      rdy_q    <= adc_rdy_i;
    end
  end

  // Result handshake: res_valid_o rises on entering OUT and data/tag hold
  // until res_ready_i is high at a rising edge, where the transfer happens.
  assign res_valid_o = (state_q == OUT);
  assign res_data_o  = RESOLUTION'(acc_q >> avg_q);
  assign res_chan_o  = chan_q;
  assign mux_sel_o   = chan_q;
  assign adc_start_o = start_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Randomized bench for adc_sequencer: ADC and sink models plus a
// per-channel averaging reference kept as expected queues.
module tb_adc_sequencer;
  import adc_seq_pkg::*;

  localparam int SETTLE = 4;
  localparam int TMO    = 64;

  logic       clk, rst_n, enable, continuous;
  logic [3:0] chan_mask;
  logic [2:0] avg_log2;
  logic [1:0] mux_sel, res_chan;
  logic       adc_start, adc_sample, adc_rdy, res_valid, res_ready;
  logic [7:0] adc_result, res_data;
  logic       busy, done, err;
  state_t     dut_state;

  int n_checks = 0, n_errs = 0;
  int n_starts = 0, n_done = 0, n_settle_entries = 0;
  int ready_pct = 70;
  bit strict_starts = 1, hold_ready = 0, adc_hang = 0;

  logic [9:0] exp_q[$];
  logic [1:0] exp_start_q[$];
  logic [7:0] adc_vals_q[$];

  adc_sequencer #(
    .RESOLUTION(8), .NUM_CH(4), .MAX_AVG_LOG2(4),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .continuous_i(continuous),
    .chan_mask_i(chan_mask), .avg_log2_i(avg_log2), .mux_sel_o(mux_sel),
    .adc_start_o(adc_start), .adc_sample_i(adc_sample), .adc_rdy_i(adc_rdy),
    .adc_result_i(adc_result), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_chan_o(res_chan), .busy_o(busy), .done_o(done),
    .err_o(err), .state_o(dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", n_errs);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model: each start returns the next queued sample after 2..10 clocks.
  initial begin : adc_model
    int lat;
    adc_rdy = 1'b0; adc_sample = 1'b0; adc_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && adc_start && !adc_hang) begin
        adc_rdy = 1'b0; adc_sample = 1'b1;
        lat = $urandom_range(2, 10);
        repeat (lat) @(negedge clk);
        adc_sample = 1'b0;
        adc_result = (adc_vals_q.size() != 0) ? adc_vals_q.pop_front() : 8'h00;
        adc_rdy = 1'b1;
      end
    end
  end

  // Monitors and result sink with scoreboard.
  initial begin : monitor
    logic prev_start, prev_hold;
    logic [9:0] held;
    state_t prev_state;
    prev_start = 1'b0; prev_hold = 1'b0; held = '0; prev_state = IDLE;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (adc_start) begin
          n_starts++;
          check("start_single_cycle", prev_start, 0);
          check("start_expected", (exp_start_q.size() != 0) || !strict_starts, 1);
          if (exp_start_q.size() != 0) check("mux_at_start", mux_sel, exp_start_q.pop_front());
        end
        prev_start = adc_start;
        if (dut_state == SETTLE && prev_state != SETTLE) n_settle_entries++;
        prev_state = dut_state;
        if (done) n_done++;
        if (prev_hold) begin
          check("hold_valid", res_valid, 1);
          check("hold_payload", {res_chan, res_data}, held);
        end
        res_ready = !hold_ready && ($urandom_range(0, 99) < ready_pct);
        prev_hold = res_valid && !res_ready;
        held = {res_chan, res_data};
        if (res_valid && res_ready) begin
          check("res_pending", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("res_payload", {res_chan, res_data}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic plan_chan(input int ch, input int n_avg, input int fixed);
    int sum, v;
    sum = 0;
    for (int i = 0; i < (1 << n_avg); i++) begin
      v = (fixed >= 0) ? fixed : int'($urandom_range(0, 255));
      adc_vals_q.push_back(8'(v));
      exp_start_q.push_back(2'(ch));
      sum += v;
    end
    exp_q.push_back({2'(ch), 8'(sum >> n_avg)});
  endtask

  task automatic launch(input logic [3:0] mask, input logic [2:0] avg, input logic cont);
    @(negedge clk);
    chan_mask = mask; avg_log2 = avg; continuous = cont; enable = 1'b1;
  endtask

  task automatic wait_start(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!adc_start && k < 60);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (done) enable = 1'b0;
    end while (busy && n < budget);
    check({tag, "_idle_in_budget"}, busy, 0);
    enable = 1'b0;
  endtask

  task automatic finish_test(input string tag);
    check({tag, "_results_left"}, exp_q.size(), 0);
    check({tag, "_starts_left"}, exp_start_q.size(), 0);
    exp_q.delete(); exp_start_q.delete(); adc_vals_q.delete();
  endtask

  initial begin : stimulus
    int k, d0, s0, e0, eff;
    logic [3:0] m;
    logic [2:0] a;
    rst_n = 1'b0; enable = 1'b0; continuous = 1'b0; chan_mask = '0; avg_log2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_start", adc_start, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mux", mux_sel, 0);
    check("rst_payload", {res_chan, res_data}, 0);
    check("rst_state", dut_state, IDLE);
    rst_n = 1'b1;

    // Two channels, no averaging, fixed ADC values.
    plan_chan(1, 0, 'h40);
    plan_chan(3, 0, 'hC0);
    d0 = n_done;
    launch(4'b1010, 3'd0, 1'b0);
    wait_start(k);
    check("first_start_latency", k, SETTLE + 2);
    wait_idle("seq1", 300);
    check("seq1_done_pulses", n_done - d0, 1);
    check("seq1_err", err, 0);
    finish_test("seq1");

    // Averaging of four samples on one channel without resettling.
    for (int i = 10; i <= 13; i++) begin
      adc_vals_q.push_back(8'(i));
      exp_start_q.push_back(2'd0);
    end
    exp_q.push_back({2'd0, 8'h0B});
    s0 = n_starts; e0 = n_settle_entries;
    launch(4'b0001, 3'd2, 1'b0);
    wait_idle("avg4", 300);
    check("avg4_starts", n_starts - s0, 4);
    check("avg4_settles", n_settle_entries - e0, 1);
    finish_test("avg4");

    // Back-pressure in OUT.
    plan_chan(2, 0, -1);
    hold_ready = 1'b1;
    launch(4'b0100, 3'd0, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!res_valid && k < 100);
    check("hold_reached_out", res_valid, 1);
    s0 = n_starts;
    repeat (20) @(negedge clk);
    check("hold_no_start", n_starts - s0, 0);
    hold_ready = 1'b0;
    wait_idle("hold", 100);
    finish_test("hold");

    // Continuous mode: mask change only takes effect at the wrap.
    plan_chan(0, 0, -1);
    plan_chan(2, 0, -1);
    d0 = n_done;
    launch(4'b0001, 3'd0, 1'b1);
    @(negedge clk);
    chan_mask = 4'b0100;
    k = 0;
    do begin @(negedge clk); k++; end while (!(res_valid && res_chan == 2'd2) && k < 200);
    check("cont_reached_ch2", res_valid && res_chan == 2'd2, 1);
    enable = 1'b0;
    wait_idle("cont", 100);
    check("cont_no_done", n_done - d0, 0);
    finish_test("cont");

    // Timeout, sticky error, cleared by a new start.
    adc_hang = 1'b1; strict_starts = 1'b0;
    launch(4'b0001, 3'd0, 1'b0);
    wait_start(k);
    k = 0;
    do begin @(negedge clk); k++; end while (!err && k < TMO + 20);
    enable = 1'b0;
    check("tmo_err_set", err, 1);
    check("tmo_latency_in_range", (k >= TMO) && (k <= TMO + 2), 1);
    check("tmo_back_idle", busy, 0);
    repeat (5) @(negedge clk);
    check("tmo_err_sticky", err, 1);
    adc_hang = 1'b0; strict_starts = 1'b1;
    finish_test("tmo");
    plan_chan(3, 0, -1);
    launch(4'b1000, 3'd0, 1'b0);
    @(negedge clk);
    check("tmo_err_cleared", err, 0);
    wait_idle("after_tmo", 200);
    finish_test("after_tmo");

    // Stop during WAIT, then during SETTLE.
    strict_starts = 1'b0;
    d0 = n_done; s0 = n_starts;
    launch(4'b0011, 3'd1, 1'b0);
    wait_start(k);
    @(negedge clk);
    enable = 1'b0;
    wait_idle("stop_wait", 40);
    check("stop_wait_starts", n_starts - s0, 1);
    s0 = n_starts;
    launch(4'b0100, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_idle("stop_settle", 5);
    repeat (10) @(negedge clk);
    check("stop_settle_starts", n_starts - s0, 0);
    check("stop_no_done", n_done - d0, 0);
    strict_starts = 1'b1;
    finish_test("stop");

    // Random masks and averaging exponents, including saturating ones.
    for (int it = 0; it < 4; it++) begin
      m = 4'($urandom_range(1, 15));
      a = 3'($urandom_range(0, 7));
      eff = (a > 3'd4) ? 4 : int'(a);
      for (int ch = 0; ch < 4; ch++) if (m[ch]) plan_chan(ch, eff, -1);
      d0 = n_done;
      launch(m, a, 1'b0);
      wait_idle("rand", 6000);
      check("rand_done", n_done - d0, 1);
      finish_test("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
